stopwatch_display_mux: RTL and testbench
========================================

Name: stopwatch_display_mux

Overview:
Downstream display stage for the stopwatch core. Consumes the core's minutes, seconds and status outputs. Drives a 4-digit common-anode 7-segment display as MM:SS by time-multiplexing one digit at a time.
- Latches a coherent snapshot of the inputs once per scan frame, so displayed values never tear mid-frame.
- Blinks the colon while running and blanks the whole display periodically while paused.

Parameters:
REFRESH_DIV, 4, clock cycles each digit stays selected (>=2).
BLINK_FRAMES, 2, scan frames per blink half-period (>=1).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
minutes  input  8  elapsed minutes, binary (0..255).
seconds  input  6  elapsed seconds, binary (expected 0..59; not clamped).
status  input  2  stopwatch state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 treated as IDLE.
an_n  output  4  active-low digit enables; [0]=seconds ones, [1]=seconds tens, [2]=minutes ones, [3]=minutes tens.
seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
dp_n  output  1  active-low decimal point; used as colon on digit 2.
ovf  output  1  high while the snapshot minutes value is >=100.

Behaviour:
- Reset (async, rst_n=0): all registers cleared immediately, no clock required.
  - an_n=1111, seg_n=1111111, dp_n=1, ovf=0.
  - scan_cnt=0, idx=0, frame_cnt=0, blink phase=0 (visible), shadow minutes/seconds/status=0.
- Scan counter and digit index:
  - scan_cnt increments every clk.
  - At scan_cnt==REFRESH_DIV-1, scan_cnt wraps to 0 and idx advances 0->1->2->3->0.
  - Frame = 4*REFRESH_DIV cycles.
- Snapshot: on the edge where scan_cnt==REFRESH_DIV-1 and idx==3 (the frame boundary), the shadow registers load minutes, seconds and status. Input changes at any other time are invisible until the next boundary.
- Blink timing: frame_cnt increments on each frame boundary. At frame_cnt==BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Digit decode: combinational from the shadow registers.
  - Seconds: ones = s%10, tens = s/10.
  - Minutes 0..99: ones = m%10, tens = m/10.
  - Minutes >=100: digits 2 and 3 both show dash (seg_n=0111111) and ovf=1.
  - No leading-zero suppression.
- Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111.
- Output timing: an_n, seg_n, dp_n and ovf are registered from the current idx and shadow values, giving 1-cycle latency.
  - The edge that changes idx is followed one edge later by outputs for the new digit.
  - The first edge after reset release shows digit 0 of the zero shadow.
- Mode rules, applied to the registered outputs:
  - IDLE/11: all digits lit; dp_n=0 when idx==2, else 1.
  - RUNNING: all digits lit; dp_n=0 on idx==2 only when phase=0, else 1.
  - PAUSED, phase=0: digits lit, dp_n=0 on idx==2.
  - PAUSED, phase=1: an_n=1111, seg_n=1111111, dp_n=1.
- A status change affects outputs only after the next snapshot. Phase keeps running in every mode. A change of mode does not reset the phase.
- Simultaneous events: snapshot, idx wrap and frame_cnt update all occur on the same edge; the new snapshot is used from the following output update.
- Reset mid-frame: outputs return to reset values asynchronously. After release, scanning restarts at idx=0, scan_cnt=0.

Test Plan:
1. Reset and first frame (REFRESH_DIV=4, BLINK_FRAMES=2):
   - Hold rst_n=0 -> an_n=1111, seg_n=1111111, dp_n=1.
   - Release with minutes=12, seconds=34, status=01 -> edges 1-16 show 0 (1000000) on an_n 1110,1101,1011,0111 in turn.
   - Edge 17 -> an_n=1110, seg_n=0011001 ("4"). Edge 21 -> "3". Edge 25 -> "2". Edge 29 -> "1".
2. Tear-free snapshot: change seconds 34->35 at cycle 20 -> digit 0 still "4" through frame 2; after edge 33, digit 0 is 0010010 ("5").
3. Overflow: minutes=150, seconds=7 -> after next snapshot, ovf=1; digits 3,2 = 0111111; digit 1 = 1000000; digit 0 = 1111000.
4. Paused blink: status=10 held -> repeating pattern of 2 frames visible (dp_n=0 during digit 2) then 2 frames with an_n=1111, seg_n=1111111, dp_n=1.
5. Running colon: status=01 -> digits never blank; dp_n pulses low on digit 2 in frames with phase 0 only, toggling every 2 frames. status=00 -> dp_n low on every digit-2 slot.
6. Async reset mid-operation: drop rst_n at cycle 10 between clock edges -> outputs reach reset values without a clock edge. After release, sequence restarts exactly as in scenario 1.

Source files
------------

// File: rtl/stopwatch_display_mux.sv
// Multiplexes a stopwatch MM:SS value onto a 4-digit common-anode 7-segment display.
// Inputs are snapshotted once per scan frame; the colon blinks while running and the display blinks while paused.
module stopwatch_display_mux #(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       ovf
);

  localparam int unsigned SCAN_W  = $clog2(REFRESH_DIV);
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSE  = 2'b10;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               phase;
  logic [7:0]         sh_min;
  logic [5:0]         sh_sec;
  logic [1:0]         sh_status;

  logic       scan_wrap;
  logic       frame_end;
  logic       min_ovf;
  logic [3:0] s_ones, s_tens, m_ones, m_tens;
  logic [6:0] digit_seg;
  logic       blank;
  logic       colon;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign scan_wrap = (scan_cnt == SCAN_W'(REFRESH_DIV - 1));
  assign frame_end = scan_wrap && (idx == 2'd3);
  assign min_ovf   = (sh_min >= 8'd100);

  // Scan timing, blink phase and per-frame snapshot of the inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      sh_min    <= '0;
      sh_sec    <= '0;
      sh_status <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_wrap) idx <= idx + 2'd1;
      if (frame_end) begin
        sh_min    <= minutes;
        sh_sec    <= seconds;
        sh_status <= status;
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // Digit decode and mode masking for the currently selected digit
  always_comb begin
    s_ones    = 4'(sh_sec % 6'd10);
    s_tens    = 4'(sh_sec / 6'd10);
    m_ones    = 4'(sh_min % 8'd10);
    m_tens    = 4'(sh_min / 8'd10);
    digit_seg = SEG_BLANK;
    case (idx)
      2'd0: digit_seg = seg_lut(s_ones);
      2'd1: digit_seg = seg_lut(s_tens);
      2'd2: digit_seg = min_ovf ? SEG_DASH : seg_lut(m_ones);
      2'd3: digit_seg = min_ovf ? SEG_DASH : seg_lut(m_tens);
      default: digit_seg = SEG_BLANK;
    endcase
    blank = (sh_status == ST_PAUSE) && phase;
    colon = (idx == 2'd2) && !((sh_status == ST_RUN) && phase);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_d = blank ? SEG_BLANK : digit_seg;
    dp_d  = blank ? 1'b1 : ~colon;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= 4'b1111;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
      ovf   <= min_ovf;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Self-checking bench for stopwatch_display_mux: directed sequences, a vector table and random stimulus
// checked against an edge-count based reference model.
module tb_stopwatch_display_mux;

  localparam int unsigned R  = 4;
  localparam int unsigned B  = 2;
  localparam int unsigned FR = 4 * R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [1:0] status = '0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release and the values the display should be showing
  int         edge_cnt = 0;
  logic [7:0] sh_m = '0;
  logic [5:0] sh_s = '0;
  logic [1:0] sh_st = '0;

  typedef struct {
    logic [7:0]      m;
    logic [5:0]      s;
    logic [1:0]      st;
    logic [3:0][6:0] segs;
    logic            ovf;
  } vec_t;

  vec_t vecs[7];

  stopwatch_display_mux #(.REFRESH_DIV(R), .BLINK_FRAMES(B)) dut (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds), .status(status),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  // One clock edge: predict the outputs from the model, update the snapshot, then compare
  task automatic step();
    int d, f, ph, mi, si;
    logic [6:0] es;
    logic [3:0] ea;
    logic       ed, eo, blank, colon;
    @(posedge clk);
    edge_cnt++;
    d  = ((edge_cnt - 1) / R) % 4;
    f  = (edge_cnt - 1) / FR;
    ph = (f / B) % 2;
    mi = int'(sh_m);
    si = int'(sh_s);
    eo = (mi >= 100);
    case (d)
      0: es = seg_of(si % 10);
      1: es = seg_of(si / 10);
      2: es = eo ? 7'b0111111 : seg_of(mi % 10);
      default: es = eo ? 7'b0111111 : seg_of(mi / 10);
    endcase
    ea    = ~(4'b0001 << d);
    blank = (sh_st == 2'b10) && (ph == 1);
    if (sh_st == 2'b01) colon = (d == 2) && (ph == 0);
    else                colon = (d == 2);
    ed = ~colon;
    if (blank) begin
      ea = 4'b1111;
      es = 7'b1111111;
      ed = 1'b1;
    end
    if (edge_cnt % FR == 0) begin
      sh_m  = minutes;
      sh_s  = seconds;
      sh_st = status;
    end
    #1;
    chk("an_n", int'(an_n), int'(ea));
    chk("seg_n", int'(seg_n), int'(es));
    chk("dp_n", int'(dp_n), int'(ed));
    chk("ovf", int'(ovf), int'(eo));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an_n"}, int'(an_n), 4'b1111);
    chk({tag, "_seg_n"}, int'(seg_n), 7'b1111111);
    chk({tag, "_dp_n"}, int'(dp_n), 1);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  // Drop reset between edges, confirm the asynchronous clear, release on a falling edge
  task automatic hard_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst_n    = 1'b1;
    edge_cnt = 0;
    sh_m     = '0;
    sh_s     = '0;
    sh_st    = '0;
  endtask

  task automatic first_frames(input string tag);
    minutes = 8'd12;
    seconds = 6'd34;
    status  = 2'b01;
    for (int i = 0; i < 16; i++) step();
    step();
    chk({tag, "_e17_an"}, int'(an_n), 4'b1110);
    chk({tag, "_e17_seg"}, int'(seg_n), 7'b0011001);
  endtask

  initial begin
    vecs[0] = '{8'd12,  6'd34, 2'b01, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
    vecs[1] = '{8'd150, 6'd7,  2'b00, {7'b0111111, 7'b0111111, 7'b1000000, 7'b1111000}, 1'b1};
    vecs[2] = '{8'd99,  6'd59, 2'b11, {7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000}, 1'b0};
    vecs[3] = '{8'd100, 6'd0,  2'b01, {7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000}, 1'b1};
    vecs[4] = '{8'd0,   6'd63, 2'b00, {7'b1000000, 7'b1000000, 7'b0000010, 7'b0110000}, 1'b0};
    vecs[5] = '{8'd255, 6'd10, 2'b01, {7'b0111111, 7'b0111111, 7'b1111001, 7'b1000000}, 1'b1};
    vecs[6] = '{8'd8,   6'd26, 2'b11, {7'b1000000, 7'b0000000, 7'b0100100, 7'b0000010}, 1'b0};

    // Power-on reset and the first two frames
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_frames("start");

    // Seconds change mid-frame must not tear the display
    for (int i = 0; i < 3; i++) step();
    seconds = 6'd35;
    while (edge_cnt < 33) step();
    chk("tear_e33_an", int'(an_n), 4'b1110);
    chk("tear_e33_seg", int'(seg_n), 7'b0010010);

    // Asynchronous reset partway through a frame, then a clean restart
    while (edge_cnt % FR != 10) step();
    hard_reset("midrst");
    first_frames("restart");

    // Table vectors: load at a boundary, scribble the inputs mid-frame, check the frame shown
    for (int v = 0; v < 7; v++) begin
      minutes = vecs[v].m;
      seconds = vecs[v].s;
      status  = vecs[v].st;
      do step(); while (edge_cnt % FR != 0);
      for (int k = 1; k <= int'(FR); k++) begin
        step();
        if (k == 5) begin
          minutes = 8'($urandom);
          seconds = 6'($urandom);
        end
        chk($sformatf("vec%0d_seg", v), int'(seg_n), int'(vecs[v].segs[((edge_cnt - 1) / R) % 4]));
        chk($sformatf("vec%0d_ovf", v), int'(ovf), int'(vecs[v].ovf));
      end
    end

    // Blink behaviour held over several frames in each mode
    minutes = 8'd42;
    seconds = 6'd17;
    status  = 2'b10;
    for (int i = 0; i < 8 * int'(FR); i++) step();
    status = 2'b01;
    for (int i = 0; i < 8 * int'(FR); i++) step();
    status = 2'b00;
    for (int i = 0; i < 4 * int'(FR); i++) step();

    // Random inputs changed at random points, with statuses held long enough to see blinking
    for (int n = 0; n < 40; n++) begin
      int hold;
      hold = int'($urandom_range(3 * FR, 1));
      if ($urandom_range(3, 0) == 0) minutes = 8'($urandom_range(110, 90));
      else                           minutes = 8'($urandom);
      seconds = 6'($urandom);
      if ($urandom_range(2, 0) == 0) status = 2'($urandom);
      for (int i = 0; i < hold; i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
